// File: rtl/instr_queue.sv
// instr_queue: expands compact vector instructions into per-copy micro-ops.
// Copies are placed into a linear slot array with one lane per unit type.
// Each pop presents the DMA, math and regfile/cache entries of one slot.
//
// Packed output layouts (MSB first):
//   out_dma_instr   {valid, mem_we, main_mem_addr[6:0], cache_slot[1:0], cache_addr[10:0]}
//   out_math_instr  {valid, op[0:8]}
//   out_cache_instr {valid, is_load, cache_slot[1:0], cache_addr[10:0], regfile_reg[1:0], aux[1:0]}
module instr_queue #(
  parameter int LOG_SUPERSCALAR_WIDTH = 4,
  parameter int DEPTH                 = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           re,
  output logic [21:0]                    out_dma_instr,
  output logic [9:0]                     out_math_instr,
  output logic [18:0]                    out_cache_instr,
  output logic                           empty,
  input  logic                           we,
  input  logic [1:0]                     in_instr_type,
  input  logic [LOG_SUPERSCALAR_WIDTH:0] copy_count,
  input  logic [10:0]                    cache_addr,
  input  logic [10:0]                    d_cache_addr,
  input  logic [6:0]                     main_mem_addr,
  input  logic [6:0]                     d_main_mem_addr,
  input  logic [0:8]                     in_arith_instr,
  input  logic [0:2]                     in_ram_instr,
  input  logic [0:6]                     in_ld_st_instr,
  output logic                           needs_reset
);

  localparam logic [1:0] INSTR_TYPE_RAM        = 2'd0;
  localparam logic [1:0] INSTR_TYPE_LOAD_STORE = 2'd1;
  localparam logic [1:0] INSTR_TYPE_ARITHMETIC = 2'd2;

  localparam int MAXC = 1 << LOG_SUPERSCALAR_WIDTH;
  localparam int CW   = LOG_SUPERSCALAR_WIDTH + 1;
  // Position width leaves headroom for start + count beyond DEPTH.
  localparam int PW   = $clog2(DEPTH + MAXC + 3) + 1;
  localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [CW-1:0] MAXC_C  = CW'(MAXC);

  logic [21:0]   dma_q   [DEPTH];
  logic [21:0]   dma_d   [DEPTH];
  logic [9:0]    math_q  [DEPTH];
  logic [9:0]    math_d  [DEPTH];
  logic [18:0]   cache_q [DEPTH];
  logic [18:0]   cache_d [DEPTH];

  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] nf_q [3];
  logic [PW-1:0] nf_d [3];
  logic [PW-1:0] last_start_q, last_start_d;
  logic [1:0]    last_type_q, last_type_d;
  logic          has_prev_q, has_prev_d;
  logic          needs_reset_q, needs_reset_d;
  logic [21:0]   out_dma_q, out_dma_d;
  logic [9:0]    out_math_q, out_math_d;
  logic [18:0]   out_cache_q, out_cache_d;

  logic [PW-1:0] n_clamp, lat, chain_start, rp_next, lane_free, start, end_pos, max_nf, slot;
  logic          type_ok, do_write, write_ok, rd_ok;
  logic [10:0]   ca_run;
  logic [6:0]    ma_run;

  // Placement: the write start honours lane order, the post-pop read position and the latency chain.
  always_comb begin
    type_ok     = (in_instr_type != 2'd3);
    n_clamp     = (copy_count > MAXC_C) ? PW'(MAXC) : PW'(copy_count);
    lat         = (last_type_q == INSTR_TYPE_RAM) ? PW'(2) : PW'(1);
    chain_start = has_prev_q ? (last_start_q + lat) : '0;
    rd_ok       = re && (rp_q < DEPTH_P);
    rp_next     = rd_ok ? (rp_q + PW'(1)) : rp_q;
    case (in_instr_type)
      INSTR_TYPE_RAM:        lane_free = nf_q[0];
      INSTR_TYPE_LOAD_STORE: lane_free = nf_q[1];
      INSTR_TYPE_ARITHMETIC: lane_free = nf_q[2];
      default:               lane_free = '0;
    endcase
    start = lane_free;
    if (rp_next > start)     start = rp_next;
    if (chain_start > start) start = chain_start;
    end_pos  = start + n_clamp;
    do_write = we && type_ok && (n_clamp != '0);
    write_ok = do_write && (end_pos <= DEPTH_P);
    max_nf = nf_q[0];
    if (nf_q[1] > max_nf) max_nf = nf_q[1];
    if (nf_q[2] > max_nf) max_nf = nf_q[2];
  end

  // Slot array update: invalidate the popped slot, then expand the write into strided copies.
  always_comb begin
    dma_d   = dma_q;
    math_d  = math_q;
    cache_d = cache_q;
    ca_run  = cache_addr;
    ma_run  = main_mem_addr;
    slot    = start;
    if (rd_ok) begin
      dma_d[rp_q[IW-1:0]]   = '0;
      math_d[rp_q[IW-1:0]]  = '0;
      cache_d[rp_q[IW-1:0]] = '0;
    end
    if (write_ok) begin
      for (int i = 0; i < MAXC; i++) begin
        if (PW'(i) < n_clamp) begin
          slot = start + PW'(i);
          case (in_instr_type)
            INSTR_TYPE_RAM:
              dma_d[slot[IW-1:0]] = {1'b1, in_ram_instr[0], ma_run, in_ram_instr[1:2], ca_run};
            INSTR_TYPE_LOAD_STORE:
              cache_d[slot[IW-1:0]] = {1'b1, in_ld_st_instr[0], in_ld_st_instr[1:2], ca_run,
                                       in_ld_st_instr[3:4], in_ld_st_instr[5:6]};
            INSTR_TYPE_ARITHMETIC:
              math_d[slot[IW-1:0]] = {1'b1, in_arith_instr};
            default: ;
          endcase
        end
        ca_run = ca_run + d_cache_addr;
        ma_run = ma_run + d_main_mem_addr;
      end
    end
  end

  // Bookkeeping: read pointer, lane free pointers, chain history, overflow flag and output registers.
  always_comb begin
    rp_d          = rp_next;
    nf_d          = nf_q;
    last_start_d  = last_start_q;
    last_type_d   = last_type_q;
    has_prev_d    = has_prev_q;
    needs_reset_d = needs_reset_q | (do_write && !write_ok);
    out_dma_d     = out_dma_q;
    out_math_d    = out_math_q;
    out_cache_d   = out_cache_q;
    if (write_ok) begin
      case (in_instr_type)
        INSTR_TYPE_RAM:        nf_d[0] = end_pos;
        INSTR_TYPE_LOAD_STORE: nf_d[1] = end_pos;
        default:               nf_d[2] = end_pos;
      endcase
      last_start_d = start;
      last_type_d  = in_instr_type;
      has_prev_d   = 1'b1;
    end
    if (re) begin
      out_dma_d   = rd_ok ? dma_q[rp_q[IW-1:0]]   : '0;
      out_math_d  = rd_ok ? math_q[rp_q[IW-1:0]]  : '0;
      out_cache_d = rd_ok ? cache_q[rp_q[IW-1:0]] : '0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dma_q[i]   <= '0;
        math_q[i]  <= '0;
        cache_q[i] <= '0;
      end
      for (int l = 0; l < 3; l++) nf_q[l] <= '0;
      rp_q          <= '0;
      last_start_q  <= '0;
      last_type_q   <= '0;
      has_prev_q    <= 1'b0;
      needs_reset_q <= 1'b0;
      out_dma_q     <= '0;
      out_math_q    <= '0;
      out_cache_q   <= '0;
    end else begin
      dma_q         <= dma_d;
      math_q        <= math_d;
      cache_q       <= cache_d;
      nf_q          <= nf_d;
      rp_q          <= rp_d;
      last_start_q  <= last_start_d;
      last_type_q   <= last_type_d;
      has_prev_q    <= has_prev_d;
      needs_reset_q <= needs_reset_d;
      out_dma_q     <= out_dma_d;
      out_math_q    <= out_math_d;
      out_cache_q   <= out_cache_d;
    end
  end

  assign out_dma_instr   = out_dma_q;
  assign out_math_instr  = out_math_q;
  assign out_cache_instr = out_cache_q;
  assign needs_reset     = needs_reset_q;
  assign empty           = (rp_q >= max_nf);

endmodule

// File: tb/tb_instr_queue.sv
// Testbench for instr_queue: expected slot contents are queued when writes
// are issued and popped as each read returns its registered outputs.
module tb_instr_queue;

  localparam logic [1:0] T_RAM = 2'd0;
  localparam logic [1:0] T_LS  = 2'd1;
  localparam logic [1:0] T_AR  = 2'd2;
  localparam logic [1:0] T_BAD = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  in_instr_type = '0;
  logic [4:0]  copy_count = '0;
  logic [10:0] cache_addr = '0, d_cache_addr = '0;
  logic [6:0]  main_mem_addr = '0, d_main_mem_addr = '0;
  logic [0:8]  in_arith_instr = '0;
  logic [0:2]  in_ram_instr = '0;
  logic [0:6]  in_ld_st_instr = '0;
  logic [21:0] out_dma_instr;
  logic [9:0]  out_math_instr;
  logic [18:0] out_cache_instr;
  logic        empty, needs_reset;

  typedef struct packed {
    logic [21:0] d;
    logic [9:0]  m;
    logic [18:0] c;
  } exp_t;

  exp_t        sbq[$];
  logic [50:0] obs, expv;
  int          total = 0;
  int          bad = 0;

  instr_queue #(.LOG_SUPERSCALAR_WIDTH(4), .DEPTH(64)) dut (
    .clk(clk), .reset(reset), .re(re),
    .out_dma_instr(out_dma_instr), .out_math_instr(out_math_instr),
    .out_cache_instr(out_cache_instr), .empty(empty),
    .we(we), .in_instr_type(in_instr_type), .copy_count(copy_count),
    .cache_addr(cache_addr), .d_cache_addr(d_cache_addr),
    .main_mem_addr(main_mem_addr), .d_main_mem_addr(d_main_mem_addr),
    .in_arith_instr(in_arith_instr), .in_ram_instr(in_ram_instr),
    .in_ld_st_instr(in_ld_st_instr), .needs_reset(needs_reset)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] mk_dma(logic mw, logic [1:0] sl, logic [6:0] ma, logic [10:0] ca);
    return {1'b1, mw, ma, sl, ca};
  endfunction

  function automatic logic [18:0] mk_cache(logic ld, logic [1:0] sl, logic [10:0] ca,
                                            logic [1:0] rg, logic [1:0] ax);
    return {1'b1, ld, sl, ca, rg, ax};
  endfunction

  function automatic logic [9:0] mk_math(logic [8:0] op);
    return {1'b1, op};
  endfunction

  function automatic void push_exp(logic [21:0] d, logic [9:0] m, logic [18:0] c);
    sbq.push_back({d, m, c});
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    re = 1'b0;
    we = 1'b0;
    sbq.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic write_instr(input logic [1:0] t, input logic [4:0] n,
                             input logic [10:0] ca, input logic [10:0] dca,
                             input logic [6:0] ma, input logic [6:0] dma_s,
                             input logic [8:0] ar, input logic [2:0] ram, input logic [6:0] ls);
    in_instr_type   = t;
    copy_count      = n;
    cache_addr      = ca;
    d_cache_addr    = dca;
    main_mem_addr   = ma;
    d_main_mem_addr = dma_s;
    in_arith_instr  = ar;
    in_ram_instr    = ram;
    in_ld_st_instr  = ls;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic read_slot();
    exp_t e;
    if (sbq.size() > 0) e = sbq.pop_front();
    else e = '1;
    re = 1'b1;
    @(posedge clk);
    #1;
    re = 1'b0;
    obs  = {out_dma_instr, out_math_instr, out_cache_instr};
    expv = e;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (out_dma_instr !== 22'd0) begin bad++; $display("[TB] FAIL reset_dma: got %h expected 0", out_dma_instr); end
    total++;
    if (out_math_instr !== 10'd0) begin bad++; $display("[TB] FAIL reset_math: got %h expected 0", out_math_instr); end
    total++;
    if (out_cache_instr !== 19'd0) begin bad++; $display("[TB] FAIL reset_cache: got %h expected 0", out_cache_instr); end
    total++;
    if (empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_empty: got %b expected 1", empty); end
    total++;
    if (needs_reset !== 1'b0) begin bad++; $display("[TB] FAIL reset_needs_reset: got %b expected 0", needs_reset); end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_arith_stream();
    do_reset();
    push_exp('0, '0, '0);
    read_slot();
    total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL arith_first_read: got %h expected %h", obs, expv); end
    write_instr(T_AR, 5'd16, '0, '0, '0, '0, 9'b000110000, '0, '0);
    write_instr(T_AR, 5'd16, '0, '0, '0, '0, 9'b000110000, '0, '0);
    total++;
    if (empty !== 1'b0) begin bad++; $display("[TB] FAIL arith_not_empty: got %b expected 0", empty); end
    for (int k = 0; k < 32; k++) push_exp('0, 10'b1000110000, '0);
    push_exp('0, '0, '0);
    for (int k = 0; k < 33; k++) begin
      read_slot();
      total++;
      if (obs !== expv) begin bad++; $display("[TB] FAIL arith_read%0d: got %h expected %h", k, obs, expv); end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("[TB] FAIL arith_drained_empty: got %b expected 1", empty); end
  endtask

  task automatic test_program();
    logic [21:0] d;
    logic [9:0]  m;
    logic [18:0] c;
    do_reset();
    write_instr(T_RAM, 5'd16, 11'd0,   11'd1, 7'd32, 7'd4, '0,     3'b0_00, '0);
    write_instr(T_LS,  5'd16, 11'd0,   11'd1, '0,    '0,   '0,     '0,      7'b1_00_00_00);
    write_instr(T_AR,  5'd16, '0,      '0,    '0,    '0,   9'h0A5, '0,      '0);
    write_instr(T_LS,  5'd16, 11'd500, 11'd3, '0,    '0,   '0,     '0,      7'b0_01_10_00);
    write_instr(T_RAM, 5'd16, 11'd100, 11'd2, 7'd64, 7'd1, '0,     3'b1_01, '0);
    // Starts follow max(lane free, chain): RAM 0, LD 2, ARITH 3, ST 18, RAM write 19.
    for (int p = 0; p < 36; p++) begin
      d = '0; m = '0; c = '0;
      if (p < 16) d = mk_dma(1'b0, 2'd0, 7'(32 + 4 * p), 11'(p));
      if (p >= 19 && p < 35) d = mk_dma(1'b1, 2'd1, 7'(64 + (p - 19)), 11'(100 + 2 * (p - 19)));
      if (p >= 3 && p < 19) m = mk_math(9'h0A5);
      if (p >= 2 && p < 18) c = mk_cache(1'b1, 2'd0, 11'(p - 2), 2'd0, 2'd0);
      if (p >= 18 && p < 34) c = mk_cache(1'b0, 2'd1, 11'(500 + 3 * (p - 18)), 2'd2, 2'd0);
      push_exp(d, m, c);
    end
    for (int k = 0; k < 36; k++) begin
      read_slot();
      total++;
      if (obs !== expv) begin bad++; $display("[TB] FAIL program_slot%0d: got %h expected %h", k, obs, expv); end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("[TB] FAIL program_empty: got %b expected 1", empty); end
  endtask

  task automatic test_chain_n1();
    do_reset();
    write_instr(T_RAM, 5'd1, 11'd7,  '0, 7'd10, '0, '0,     3'b0_00, '0);
    write_instr(T_LS,  5'd1, 11'd20, '0, '0,    '0, '0,     '0,      7'b1_10_01_11);
    write_instr(T_AR,  5'd1, '0,     '0, '0,    '0, 9'h1FF, '0,      '0);
    write_instr(T_LS,  5'd1, 11'd30, '0, '0,    '0, '0,     '0,      7'b0_11_10_01);
    write_instr(T_RAM, 5'd1, 11'd40, '0, 7'd99, '0, '0,     3'b1_01, '0);
    push_exp(mk_dma(1'b0, 2'd0, 7'd10, 11'd7), '0, '0);
    push_exp('0, '0, '0);
    push_exp('0, '0, mk_cache(1'b1, 2'd2, 11'd20, 2'd1, 2'd3));
    push_exp('0, mk_math(9'h1FF), '0);
    push_exp('0, '0, mk_cache(1'b0, 2'd3, 11'd30, 2'd2, 2'd1));
    push_exp(mk_dma(1'b1, 2'd1, 7'd99, 11'd40), '0, '0);
    push_exp('0, '0, '0);
    for (int k = 0; k < 7; k++) begin
      read_slot();
      total++;
      if (obs !== expv) begin bad++; $display("[TB] FAIL chain_slot%0d: got %h expected %h", k, obs, expv); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    in_instr_type   = T_LS;
    copy_count      = 5'd2;
    cache_addr      = 11'd50;
    d_cache_addr    = 11'd5;
    main_mem_addr   = '0;
    d_main_mem_addr = '0;
    in_ld_st_instr  = 7'b1_01_11_10;
    push_exp('0, '0, '0);
    re = 1'b1;
    we = 1'b1;
    @(posedge clk);
    #1;
    re = 1'b0;
    we = 1'b0;
    e = sbq.pop_front();
    obs = {out_dma_instr, out_math_instr, out_cache_instr};
    total++;
    if (obs !== e) begin bad++; $display("[TB] FAIL b2b_same_cycle: got %h expected %h", obs, e); end
    push_exp('0, '0, mk_cache(1'b1, 2'd1, 11'd50, 2'd3, 2'd2));
    push_exp('0, '0, mk_cache(1'b1, 2'd1, 11'd55, 2'd3, 2'd2));
    push_exp('0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      read_slot();
      total++;
      if (obs !== expv) begin bad++; $display("[TB] FAIL b2b_slot%0d: got %h expected %h", k + 1, obs, expv); end
    end
  endtask

  task automatic test_clamp_ignore();
    do_reset();
    write_instr(T_BAD, 5'd4, '0, '0, '0, '0, 9'h111, 3'b111, 7'h7F);
    write_instr(T_AR,  5'd0, '0, '0, '0, '0, 9'h111, '0, '0);
    total++;
    if (empty !== 1'b1) begin bad++; $display("[TB] FAIL ignored_writes_empty: got %b expected 1", empty); end
    write_instr(T_AR, 5'd31, '0, '0, '0, '0, 9'h055, '0, '0);
    total++;
    if (empty !== 1'b0) begin bad++; $display("[TB] FAIL clamp_not_empty: got %b expected 0", empty); end
    for (int k = 0; k < 16; k++) push_exp('0, mk_math(9'h055), '0);
    push_exp('0, '0, '0);
    for (int k = 0; k < 17; k++) begin
      read_slot();
      total++;
      if (obs !== expv) begin bad++; $display("[TB] FAIL clamp_slot%0d: got %h expected %h", k, obs, expv); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int w = 0; w < 4; w++) write_instr(T_AR, 5'd16, '0, '0, '0, '0, 9'(w + 1), '0, '0);
    total++;
    if (needs_reset !== 1'b0) begin bad++; $display("[TB] FAIL overflow_before: got %b expected 0", needs_reset); end
    write_instr(T_AR, 5'd16, '0, '0, '0, '0, 9'h1EE, '0, '0);
    total++;
    if (needs_reset !== 1'b1) begin bad++; $display("[TB] FAIL overflow_flag: got %b expected 1", needs_reset); end
    for (int s = 0; s < 64; s++) push_exp('0, mk_math(9'(s / 16 + 1)), '0);
    push_exp('0, '0, '0);
    push_exp('0, '0, '0);
    for (int k = 0; k < 66; k++) begin
      read_slot();
      total++;
      if (obs !== expv) begin bad++; $display("[TB] FAIL overflow_slot%0d: got %h expected %h", k, obs, expv); end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty: got %b expected 1", empty); end
    total++;
    if (needs_reset !== 1'b1) begin bad++; $display("[TB] FAIL overflow_sticky: got %b expected 1", needs_reset); end
    do_reset();
    total++;
    if (needs_reset !== 1'b0) begin bad++; $display("[TB] FAIL overflow_cleared: got %b expected 0", needs_reset); end
  endtask

  task automatic test_async_reset();
    do_reset();
    write_instr(T_RAM, 5'd4, 11'd9, 11'd1, 7'd5, 7'd1, '0, 3'b0_10, '0);
    push_exp(mk_dma(1'b0, 2'd2, 7'd5, 11'd9), '0, '0);
    read_slot();
    total++;
    if (obs !== expv) begin bad++; $display("[TB] FAIL async_pre_read: got %h expected %h", obs, expv); end
    #3;
    reset = 1'b0;
    #1;
    obs = {out_dma_instr, out_math_instr, out_cache_instr};
    total++;
    if (obs !== 51'd0) begin bad++; $display("[TB] FAIL async_outputs: got %h expected 0", obs); end
    total++;
    if (empty !== 1'b1) begin bad++; $display("[TB] FAIL async_empty: got %b expected 1", empty); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    sbq.delete();
    push_exp('0, '0, '0);
    push_exp('0, '0, '0);
    for (int k = 0; k < 2; k++) begin
      read_slot();
      total++;
      if (obs !== expv) begin bad++; $display("[TB] FAIL async_after_slot%0d: got %h expected %h", k, obs, expv); end
    end
  endtask

  initial begin
    test_reset();
    test_arith_stream();
    test_program();
    test_chain_n1();
    test_back_to_back();
    test_clamp_ignore();
    test_overflow();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
